// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared types and constants for the branch resolver
package branch_pkg;

  localparam int BR_DEPTH = 4;
  localparam int STAT_W   = 16;

  typedef enum logic {UPD_IDLE, UPD_PEND} upd_state_t;
  typedef enum logic {RUN, FLUSH} ctl_state_t;

endpackage

// File: rtl/branch_fifo.sv
// rtl/branch_fifo.sv - in-flight prediction queue, one direction bit per entry
module branch_fifo
  import branch_pkg::*;
#(
  parameter int DEPTH = BR_DEPTH,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          push_data,
  input  logic          pop,
  input  logic          flush,
  output logic          head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // DEPTH is a power of two, so the pointers wrap by natural overflow
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - branch prediction queue, resolve/flush and predictor handshake
// Optional BRANCH_STATS_EN adds saturating resolve/mispredict counters.
module branch_resolver
  import branch_pkg::*;
#(
  parameter int DEPTH = BR_DEPTH
) (
  input  logic clk,
  input  logic reset,
  input  logic br_fetch,
  output logic br_ready,
  output logic br_pred_valid,
  output logic br_pred_taken,
  input  logic res_valid,
  input  logic res_taken,
  output logic mispredict,
  output logic underflow_err,
  output logic pred_request,
  output logic pred_result,
  output logic pred_taken,
  input  logic pred_in
`ifdef BRANCH_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_resolved,
  output logic [STAT_W-1:0] stat_mispred
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = CW + 1;
  localparam logic [OW-1:0] DEPTH_OCC = OW'(DEPTH);

  upd_state_t upd_state;
  ctl_state_t ctl_state;

  logic          cap_valid;
  logic          upd_dir;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_head;
  logic [OW-1:0] occupancy;
  logic          fire;
  logic          has_head;
  logic          head_dir;
  logic          res_ok;
  logic          res_miss;
  logic          fifo_push;
  logic          fifo_pop;

  always_comb begin
    occupancy = OW'(fifo_count) + OW'(cap_valid);
    br_ready  = !reset && (ctl_state == RUN) && (upd_state == UPD_IDLE)
                && !fifo_full && (occupancy != DEPTH_OCC);
    fire      = br_fetch && br_ready;
    // a capture landing on an empty queue is the head this cycle
    has_head  = !fifo_empty || cap_valid;
    head_dir  = fifo_empty ? pred_in : fifo_head;
    res_ok    = res_valid && has_head && !reset;
    res_miss  = res_ok && (head_dir != res_taken);
    fifo_push = cap_valid && !(res_ok && fifo_empty);
    fifo_pop  = res_ok && !fifo_empty;

    pred_request  = fire;
    pred_result   = !reset && ((upd_state == UPD_PEND) || (res_ok && !fire));
    pred_taken    = (upd_state == UPD_PEND) ? upd_dir : res_taken;
    br_pred_valid = cap_valid && !reset;
    br_pred_taken = pred_in;
  end

  branch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (pred_in),
    .pop       (fifo_pop),
    .flush     (res_miss),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      cap_valid     <= 1'b0;
      mispredict    <= 1'b0;
      underflow_err <= 1'b0;
      upd_dir       <= 1'b0;
      ctl_state     <= RUN;
      upd_state     <= UPD_IDLE;
    end else begin
      // a branch fetched alongside a mispredicting resolve is younger and dies
      cap_valid  <= fire && !res_miss;
      mispredict <= res_miss;
      if (res_valid && !has_head) begin
        underflow_err <= 1'b1;
      end
      ctl_state <= res_miss ? FLUSH : RUN;
      case (upd_state)
        UPD_IDLE: begin
          if (res_ok && fire) begin
            upd_dir   <= res_taken;
            upd_state <= UPD_PEND;
          end
        end
        UPD_PEND: begin
          // the stored update leaves now; a fresh resolve takes its slot
          if (res_ok) begin
            upd_dir <= res_taken;
          end else begin
            upd_state <= UPD_IDLE;
          end
        end
        default: upd_state <= UPD_IDLE;
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_resolved <= '0;
      stat_mispred  <= '0;
    end else begin
      if (res_ok && (stat_resolved != '1)) begin
        stat_resolved <= stat_resolved + STAT_W'(1);
      end
      if (res_miss && (stat_mispred != '1)) begin
        stat_mispred <= stat_mispred + STAT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// tb/tb_branch_resolver.sv - scoreboard bench for branch_resolver against a queue-based reference model
module tb_branch_resolver;

  localparam int DEPTH = 4;

  logic clk;
  logic reset;
  logic br_fetch;
  logic br_ready;
  logic br_pred_valid;
  logic br_pred_taken;
  logic res_valid;
  logic res_taken;
  logic mispredict;
  logic underflow_err;
  logic pred_request;
  logic pred_result;
  logic pred_taken;
  logic pred_in;
`ifdef BRANCH_STATS_EN
  logic [15:0] stat_resolved;
  logic [15:0] stat_mispred;
`endif

  branch_resolver #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .br_fetch      (br_fetch),
    .br_ready      (br_ready),
    .br_pred_valid (br_pred_valid),
    .br_pred_taken (br_pred_taken),
    .res_valid     (res_valid),
    .res_taken     (res_taken),
    .mispredict    (mispredict),
    .underflow_err (underflow_err),
    .pred_request  (pred_request),
    .pred_result   (pred_result),
    .pred_taken    (pred_taken),
    .pred_in       (pred_in)
`ifdef BRANCH_STATS_EN
    ,
    .stat_resolved (stat_resolved),
    .stat_mispred  (stat_mispred)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit ready;
    bit req;
    bit res;
    bit pv;
    bit mis;
    bit uf;
  } cyc_t;

  cyc_t cyc_q[$];
  bit   exp_pred_q[$];
  bit   exp_upd_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // reference model state: known predictions oldest first, plus pending items
  bit m_q[$];
  bit m_inflight = 0;
  bit m_pend     = 0;
  bit m_flush    = 0;
  bit m_mis      = 0;
  bit m_uf       = 0;
  int m_sres     = 0;
  int m_smis     = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit rst, input bit f, input bit rv, input bit rt, input bit pin);
    cyc_t c;
    bit   rdy;
    bit   fire;
    bit   vres;
    bit   miss;
    bit   head;
    @(posedge clk);
    #1;
    reset     = rst;
    br_fetch  = f;
    res_valid = rv;
    res_taken = rt;
    pred_in   = pin;
    c.mis = m_mis;
    c.uf  = m_uf;
    if (rst) begin
      c.ready = 0; c.req = 0; c.res = 0; c.pv = 0;
      if (m_pend) void'(exp_upd_q.pop_back());
      m_q.delete();
      m_inflight = 0; m_pend = 0; m_flush = 0; m_mis = 0; m_uf = 0;
      m_sres = 0; m_smis = 0;
    end else begin
      rdy  = !m_flush && !m_pend && ((m_q.size() + int'(m_inflight)) < DEPTH);
      fire = f && rdy;
      c.ready = rdy;
      c.pv    = m_inflight;
      if (m_inflight) begin
        m_q.push_back(pin);
        exp_pred_q.push_back(pin);
      end
      vres = rv && (m_q.size() > 0);
      miss = 0;
      if (vres) begin
        head = m_q.pop_front();
        miss = (head != rt);
        exp_upd_q.push_back(rt);
        if (m_sres < 16'hFFFF) m_sres++;
        if (miss && m_smis < 16'hFFFF) m_smis++;
      end
      c.req = fire;
      c.res = m_pend || (vres && !fire);
      if (miss) m_q.delete();
      if (rv && !vres) m_uf = 1;
      m_pend     = vres && (fire || m_pend);
      m_inflight = fire && !miss;
      m_flush    = miss;
      m_mis      = miss;
    end
    cyc_q.push_back(c);
  endtask

  // monitor: samples on the falling edge, well away from the active edge
  initial begin
    cyc_t c;
    forever begin
      @(negedge clk);
      if (cyc_q.size() > 0) begin
        c = cyc_q.pop_front();
        check("br_ready", br_ready, c.ready);
        check("pred_request", pred_request, c.req);
        check("pred_result", pred_result, c.res);
        check("br_pred_valid", br_pred_valid, c.pv);
        check("mispredict", mispredict, c.mis);
        check("underflow_err", underflow_err, c.uf);
      end
      if (br_pred_valid === 1'b1 && exp_pred_q.size() > 0)
        check("br_pred_taken", br_pred_taken, exp_pred_q.pop_front());
      if (pred_result === 1'b1 && exp_upd_q.size() > 0)
        check("pred_taken", pred_taken, exp_upd_q.pop_front());
    end
  end

  initial begin
    reset = 1'b1; br_fetch = 1'b0; res_valid = 1'b0; res_taken = 1'b0; pred_in = 1'b0;

    step(1, 0, 0, 0, 0);
    step(1, 1, 1, 1, 1);

    // single branch predicted taken, resolved taken
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0);

    // fill the queue, then hold fetch against a full queue
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 1, 0);
    step(0, 1, 0, 0, 1);

    // fetch colliding with a resolve defers the update by one cycle
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 1);
    step(0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0);

    // queue {1,0,1}, head mispredicted -> flush and one dead cycle
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 1, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0);

    // resolve on an empty queue, sticky until reset
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 9) < 6,
           $urandom_range(0, 9) < 4,
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
    end
    step(0, 0, 0, 0, 0);

`ifdef BRANCH_STATS_EN
    @(negedge clk);
    check("stat_resolved", stat_resolved, m_sres);
    check("stat_mispred", stat_mispred, m_smis);
`endif

    step(1, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    check("pred_queue_drained", exp_pred_q.size(), 0);
    check("upd_queue_drained", exp_upd_q.size(), 0);
    check("cycle_queue_drained", cyc_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 Parameter: DEPTH, default 4, in-flight branch prediction queue entries (power of two, >=2).
REQ-002 clk  in  1  single clock, all state updates on posedge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 br_fetch  in  1  fetch presents a branch needing a prediction this cycle.
REQ-005 br_ready  out  1  resolver accepts br_fetch this cycle; transfer = br_fetch & br_ready.
REQ-006 br_pred_valid  out  1  prediction for the branch accepted last cycle is valid.
REQ-007 br_pred_taken  out  1  predicted direction, qualified by br_pred_valid.
REQ-008 res_valid  in  1  execute resolves the oldest in-flight branch.
REQ-009 res_taken  in  1  actual direction, qualified by res_valid.
REQ-010 mispredict  out  1  one-cycle pulse: last resolved branch direction differed from prediction.
REQ-011 underflow_err  out  1  sticky: res_valid arrived with no in-flight branch.
REQ-012 pred_request  out  1  predictor read strobe; prediction returns on pred_in next cycle.
REQ-013 pred_result  out  1  predictor update strobe; never asserted together with pred_request.
REQ-014 pred_taken  out  1  update direction, qualified by pred_result.
REQ-015 pred_in  in  1  predictor output, sampled the cycle after pred_request.

Function
REQ-016 Accepted br_fetch at cycle T SHALL drive pred_request=1 at T (combinational from the transfer) and capture pred_in at T+1.
REQ-017 At T+1 br_pred_valid=1, br_pred_taken=pred_in, and the value SHALL be pushed into the FIFO tail.
REQ-018 Occupancy SHALL count FIFO entries plus an in-flight capture; br_ready=0 when occupancy==DEPTH, when an update is pending, or in state FLUSH.
REQ-019 res_valid with non-empty FIFO SHALL pop the head at T; mispredict=(head!=res_taken) registered, visible at T+1.
REQ-020 Push and pop in the same cycle SHALL be allowed; occupancy unchanged; pointers wrap modulo DEPTH.
REQ-021 Every valid resolve SHALL produce exactly one predictor update with pred_taken=res_taken.
REQ-022 Update FSM states: UPD_IDLE, UPD_PEND. UPD_IDLE: resolve without a same-cycle pred_request drives pred_result=1 at T.
REQ-023 Resolve coinciding with pred_request SHALL store res_taken and go to UPD_PEND; in UPD_PEND, pred_result=1 next cycle, pred_request suppressed, return to UPD_IDLE.
REQ-024 Control FSM states: RUN, FLUSH. Mispredicting resolve at T: FIFO emptied and any in-flight capture discarded at T+1 (no br_pred_valid for it), state FLUSH for T+1 only, br_ready=1 again at T+2.
REQ-025 Branch accepted in the same cycle as a mispredicting resolve SHALL be flushed as younger.
REQ-026 res_valid with empty FIFO (and no capture landing that cycle) SHALL set underflow_err, not update the predictor, not pulse mispredict.
REQ-027 A capture landing in the same cycle as a resolve on an otherwise empty FIFO SHALL bypass to the head and be resolved.

Reset
REQ-028 reset SHALL clear FIFO pointers and occupancy, capture valid, underflow_err, mispredict, br_pred_valid; FSMs to RUN/UPD_IDLE; pred_result=0, pred_request=0.
REQ-029 reset SHALL take priority over all activity in the same cycle; pending updates are dropped.

Configuration
REQ-030 Macro BRANCH_STATS_EN defined: add outputs stat_resolved[15:0] and stat_mispred[15:0], saturating at 16'hFFFF, cleared by reset, incremented on valid resolve / mispredict.
REQ-031 Macro BRANCH_STATS_EN undefined: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-032 Shared package branch_pkg SHALL hold the upd_state_t and ctl_state_t enums, DEPTH default, and the stats width constant.
REQ-033 The prediction queue SHALL be a sub-module branch_fifo (push, pop, flush, full, empty, count); FSMs and predictor handshake stay in branch_resolver.

Verification
REQ-034 Reset, single br_fetch with pred_in=1 -> pred_request at T, br_pred_valid=1 & br_pred_taken=1 at T+1; res_valid res_taken=1 -> mispredict=0, pred_result=1 pred_taken=1.
REQ-035 Four back-to-back fetches (DEPTH=4), no resolves -> br_ready=0 from the fourth acceptance until the first resolve pops.
REQ-036 br_fetch and res_valid same cycle -> pred_request=1, pred_result=0 at T; pred_result=1 at T+1 with stored direction; br_ready=0 at T+1.
REQ-037 Queue holds predictions {1,0,1}; resolve head with res_taken=0 -> mispredict at T+1, count=0, br_ready=0 at T+1, 1 at T+2.
REQ-038 res_valid on empty queue -> underflow_err=1 stays set, pred_result=0, mispredict=0; reset clears it.
REQ-039 BRANCH_STATS_EN, 3 resolves with 1 mispredict -> stat_resolved=3, stat_mispred=1; preload 16'hFFFF -> holds at 16'hFFFF.
